// File: rtl/cpu64_rf_wb_arbiter_if.sv
// Writeback request/grant bus, register-file write port and scoreboard query
// signals shared between the execution units, issue stage and the arbiter.
interface cpu64_rf_wb_arbiter_if #(
   parameter int XLEN = 64
);
   logic            alu_valid_i;
   logic            lsu_valid_i;
   logic            mdu_valid_i;
   logic [4:0]      alu_rd_i;
   logic [4:0]      lsu_rd_i;
   logic [4:0]      mdu_rd_i;
   logic [XLEN-1:0] alu_data_i;
   logic [XLEN-1:0] lsu_data_i;
   logic [XLEN-1:0] mdu_data_i;
   logic            alu_ready_o;
   logic            lsu_ready_o;
   logic            mdu_ready_o;

   logic            wr_en_o;
   logic [4:0]      rd_idx_o;
   logic [XLEN-1:0] wr_data_o;

   logic            alloc_en_i;
   logic [4:0]      alloc_rd_i;
   logic [4:0]      rs1_idx_i;
   logic [4:0]      rs2_idx_i;
   logic            rs1_busy_o;
   logic            rs2_busy_o;
   logic            rd_busy_o;
   logic            err_o;

   modport slave (
      input  alu_valid_i, lsu_valid_i, mdu_valid_i,
      input  alu_rd_i, lsu_rd_i, mdu_rd_i,
      input  alu_data_i, lsu_data_i, mdu_data_i,
      output alu_ready_o, lsu_ready_o, mdu_ready_o,
      output wr_en_o, rd_idx_o, wr_data_o,
      input  alloc_en_i, alloc_rd_i, rs1_idx_i, rs2_idx_i,
      output rs1_busy_o, rs2_busy_o, rd_busy_o, err_o
   );

   modport master (
      output alu_valid_i, lsu_valid_i, mdu_valid_i,
      output alu_rd_i, lsu_rd_i, mdu_rd_i,
      output alu_data_i, lsu_data_i, mdu_data_i,
      input  alu_ready_o, lsu_ready_o, mdu_ready_o,
      input  wr_en_o, rd_idx_o, wr_data_o,
      output alloc_en_i, alloc_rd_i, rs1_idx_i, rs2_idx_i,
      input  rs1_busy_o, rs2_busy_o, rd_busy_o, err_o
   );
endinterface

// File: rtl/cpu64_rf_wb_arbiter.sv
// Round-robin writeback arbiter for the cpu64 integer register file, with a
// 31-entry pending-write scoreboard queried by the issue stage.
module cpu64_rf_wb_arbiter #(
   parameter int XLEN = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   cpu64_rf_wb_arbiter_if.slave bus
);
   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_LSU = 2'd1;
   localparam logic [1:0] SRC_MDU = 2'd2;

   logic [1:0]      last_grant_r;
   logic [2:0]      req_s;
   logic [2:0]      gnt_s;
   logic            accept_s;
   logic            write_s;
   logic [1:0]      gnt_idx_s;
   logic [4:0]      gnt_rd_s;
   logic [XLEN-1:0] gnt_data_s;

   logic            wr_en_r;
   logic [4:0]      rd_idx_r;
   logic [XLEN-1:0] wr_data_r;

   logic [31:1]     pending_r;
   logic [31:1]     pending_nxt_s;
   logic [31:0]     pend_vec_s;
   logic            err_r;

   logic            rs1_busy_s;
   logic            rs2_busy_s;
   logic            rd_busy_s;

   // Priority starts at the source after the last one granted.
   function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
      logic [2:0] gnt;
      gnt = 3'b000;
      case (last)
         SRC_ALU: begin
            if (req[1])      gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else             gnt = 3'b000;
         end
         SRC_LSU: begin
            if (req[2])      gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else             gnt = 3'b000;
         end
         default: begin
            if (req[0])      gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else             gnt = 3'b000;
         end
      endcase
      return gnt;
   endfunction

   // A retiring write is bypassed by the register file, so it is not busy.
   function automatic logic is_busy(input logic [31:0] pend, input logic [4:0] idx,
                                    input logic wen, input logic [4:0] widx);
      return pend[idx] && !(wen && (widx == idx));
   endfunction

   always_comb begin
      req_s = {bus.mdu_valid_i, bus.lsu_valid_i, bus.alu_valid_i};
      if (rst_i) begin
         gnt_s = 3'b000;
      end else begin
         gnt_s = rr_pick(req_s, last_grant_r);
      end
   end

   always_comb begin
      gnt_idx_s  = SRC_ALU;
      gnt_rd_s   = 5'd0;
      gnt_data_s = {XLEN{1'b0}};
      case (gnt_s)
         3'b001: begin
            gnt_idx_s  = SRC_ALU;
            gnt_rd_s   = bus.alu_rd_i;
            gnt_data_s = bus.alu_data_i;
         end
         3'b010: begin
            gnt_idx_s  = SRC_LSU;
            gnt_rd_s   = bus.lsu_rd_i;
            gnt_data_s = bus.lsu_data_i;
         end
         3'b100: begin
            gnt_idx_s  = SRC_MDU;
            gnt_rd_s   = bus.mdu_rd_i;
            gnt_data_s = bus.mdu_data_i;
         end
         default: begin
            gnt_idx_s  = SRC_ALU;
            gnt_rd_s   = 5'd0;
            gnt_data_s = {XLEN{1'b0}};
         end
      endcase
   end

   assign accept_s = |gnt_s;
   assign write_s  = accept_s && (gnt_rd_s != 5'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_grant_r <= SRC_MDU;
      end else if (accept_s) begin
         last_grant_r <= gnt_idx_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   // Write port: x0 transfers are accepted but never reach the file.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_en_r   <= 1'b0;
         rd_idx_r  <= 5'd0;
         wr_data_r <= {XLEN{1'b0}};
      end else begin
         wr_en_r <= write_s;
         if (write_s) begin
            rd_idx_r  <= gnt_rd_s;
            wr_data_r <= gnt_data_s;
         end else begin
            rd_idx_r  <= rd_idx_r;
            wr_data_r <= wr_data_r;
         end
      end
   end

   // Set term is OR'ed after the clear so a same-index allocation wins.
   always_comb begin
      for (int i = 1; i < 32; i++) begin
         pending_nxt_s[i] = (pending_r[i] && !(wr_en_r && (rd_idx_r == 5'(i))))
                         || (bus.alloc_en_i && (bus.alloc_rd_i == 5'(i)));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_r <= 31'd0;
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   assign pend_vec_s = {pending_r, 1'b0};

   always_comb begin
      if (rst_i) begin
         rs1_busy_s = 1'b0;
         rs2_busy_s = 1'b0;
         rd_busy_s  = 1'b0;
      end else begin
         rs1_busy_s = is_busy(pend_vec_s, bus.rs1_idx_i, wr_en_r, rd_idx_r);
         rs2_busy_s = is_busy(pend_vec_s, bus.rs2_idx_i, wr_en_r, rd_idx_r);
         rd_busy_s  = is_busy(pend_vec_s, bus.alloc_rd_i, wr_en_r, rd_idx_r);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_r <= 1'b0;
      end else if (bus.alloc_en_i && rd_busy_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.alu_ready_o = gnt_s[0];
   assign bus.lsu_ready_o = gnt_s[1];
   assign bus.mdu_ready_o = gnt_s[2];
   assign bus.wr_en_o     = wr_en_r;
   assign bus.rd_idx_o    = rd_idx_r;
   assign bus.wr_data_o   = wr_data_r;
   assign bus.rs1_busy_o  = rs1_busy_s;
   assign bus.rs2_busy_o  = rs2_busy_s;
   assign bus.rd_busy_o   = rd_busy_s;
   assign bus.err_o       = err_r;
endmodule

// File: tb/tb_cpu64_rf_wb_arbiter.sv
// Scoreboard bench for cpu64_rf_wb_arbiter: a reference model predicts grants,
// queued register-file writes, busy flags and the error flag every cycle.
module tb_cpu64_rf_wb_arbiter;
   typedef struct packed {
      logic        en;
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cpu64_rf_wb_arbiter_if #(.XLEN(64)) bus ();
   cpu64_rf_wb_arbiter #(.XLEN(64)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   logic        req_v  [3];
   logic [4:0]  req_rd [3];
   logic [63:0] req_d  [3];
   logic        alloc_en = 1'b0;
   logic [4:0]  alloc_rd = 5'd0;
   logic [4:0]  rs1 = 5'd0;
   logic [4:0]  rs2 = 5'd0;

   assign bus.alu_valid_i = req_v[0];
   assign bus.lsu_valid_i = req_v[1];
   assign bus.mdu_valid_i = req_v[2];
   assign bus.alu_rd_i    = req_rd[0];
   assign bus.lsu_rd_i    = req_rd[1];
   assign bus.mdu_rd_i    = req_rd[2];
   assign bus.alu_data_i  = req_d[0];
   assign bus.lsu_data_i  = req_d[1];
   assign bus.mdu_data_i  = req_d[2];
   assign bus.alloc_en_i  = alloc_en;
   assign bus.alloc_rd_i  = alloc_rd;
   assign bus.rs1_idx_i   = rs1;
   assign bus.rs2_idx_i   = rs2;

   int          n_vec = 0;
   int          n_err = 0;
   wr_t         exp_q[$];
   int          m_last;
   logic [31:0] m_pend;
   logic        m_err;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic post(input int s, input logic [4:0] rd, input logic [63:0] d);
      req_v[s]  = 1'b1;
      req_rd[s] = rd;
      req_d[s]  = d;
   endtask

   task automatic alloc_req(input logic [4:0] rd);
      alloc_en = 1'b1;
      alloc_rd = rd;
   endtask

   function automatic logic model_busy(input logic [4:0] idx, input wr_t cur);
      return (idx != 5'd0) && m_pend[idx] && !(cur.en && (cur.rd == idx));
   endfunction

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back('0);
      m_last = 2;
      m_pend = 32'd0;
      m_err  = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check_value({tag, "_wr_en"}, bus.wr_en_o, 1'b0);
      check_value({tag, "_rd_idx"}, bus.rd_idx_o, 5'd0);
      check_value({tag, "_wr_data"}, bus.wr_data_o, 64'd0);
      check_value({tag, "_err"}, bus.err_o, 1'b0);
      check_value({tag, "_ready"}, {bus.mdu_ready_o, bus.lsu_ready_o, bus.alu_ready_o}, 3'b000);
      check_value({tag, "_busy"}, {bus.rd_busy_o, bus.rs2_busy_o, bus.rs1_busy_o}, 3'b000);
   endtask

   // Entered at posedge+1 with inputs set; samples at the falling edge.
   task automatic step();
      logic [2:0] g;
      int         src;
      wr_t        e;
      wr_t        n;
      logic       exp_rd_busy;
      #4;
      g   = 3'b000;
      src = -1;
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (m_last + k) % 3;
         if (src < 0 && req_v[idx]) begin
            src    = idx;
            g[idx] = 1'b1;
         end
      end
      check_value("ready", {bus.mdu_ready_o, bus.lsu_ready_o, bus.alu_ready_o}, g);
      e = exp_q.pop_front();
      check_value("wr_en", bus.wr_en_o, e.en);
      if (e.en) begin
         check_value("rd_idx", bus.rd_idx_o, e.rd);
         check_value("wr_data", bus.wr_data_o, e.data);
      end
      exp_rd_busy = model_busy(alloc_rd, e);
      check_value("rs1_busy", bus.rs1_busy_o, model_busy(rs1, e));
      check_value("rs2_busy", bus.rs2_busy_o, model_busy(rs2, e));
      check_value("rd_busy", bus.rd_busy_o, exp_rd_busy);
      check_value("err", bus.err_o, m_err);
      n = '0;
      if (src >= 0) begin
         n.en   = (req_rd[src] != 5'd0);
         n.rd   = req_rd[src];
         n.data = req_d[src];
         m_last = src;
      end
      exp_q.push_back(n);
      if (e.en) m_pend[e.rd] = 1'b0;
      if (alloc_en && alloc_rd != 5'd0) m_pend[alloc_rd] = 1'b1;
      if (alloc_en && exp_rd_busy) m_err = 1'b1;
      @(posedge clk);
      #1;
      if (src >= 0) req_v[src] = 1'b0;
      alloc_en = 1'b0;
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin
         req_v[s]  = 1'b0;
         req_rd[s] = 5'd0;
         req_d[s]  = 64'd0;
      end
      post(0, 5'd5, 64'hA5);
      #1 rst = 1'b1;
      #1 check_reset("rst_init");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step();
      post(2, 5'd6, 64'h66);
      step();
      step();

      // Fairness: all three valid with rd 1,2,3.
      for (int i = 0; i < 6; i++) begin
         for (int s = 0; s < 3; s++) begin
            if (!req_v[s]) post(s, 5'(s + 1), 64'h1000 + 64'(i * 16 + s));
         end
         step();
      end
      repeat (4) step();

      // x0 write, then ALU and MDU compete.
      post(1, 5'd0, 64'hDEAD);
      step();
      post(0, 5'd10, 64'hA10);
      post(2, 5'd11, 64'hB11);
      repeat (3) step();

      // Scoreboard life cycle on x7.
      rs1 = 5'd7;
      alloc_req(5'd7);
      step();
      step();
      post(2, 5'd7, 64'h7777_0000_7777);
      repeat (3) step();

      // Set/clear collision on x9.
      rs2 = 5'd9;
      alloc_req(5'd9);
      step();
      post(0, 5'd9, 64'h9999);
      step();
      alloc_req(5'd9);
      step();
      step();

      // WAW violation on x4.
      alloc_req(5'd4);
      step();
      alloc_req(5'd4);
      step();
      step();

      // Random traffic; err must stay set.
      for (int c = 0; c < 60; c++) begin
         for (int s = 0; s < 3; s++) begin
            if (!req_v[s] && $urandom_range(0, 1) == 1)
               post(s, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         end
         if ($urandom_range(0, 3) == 0) alloc_req(5'($urandom_range(0, 31)));
         rs1 = 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         step();
      end

      // Asynchronous reset mid-cycle.
      #2 rst = 1'b1;
      #1 check_reset("rst_mid");
      for (int s = 0; s < 3; s++) req_v[s] = 1'b0;
      alloc_en = 1'b0;
      rs1 = 5'd5;
      rs2 = 5'd7;
      post(0, 5'd5, 64'hA5);
      @(posedge clk);
      #1 check_reset("rst_hold");
      rst = 1'b0;
      model_reset();
      step();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cpu64_rf_wb_arbiter.md
# cpu64_rf_wb_arbiter

Writeback arbiter and register scoreboard for the cpu64 integer register file. Three writeback sources (ALU, load/store unit, multiply/divide unit) share the file's single write port through round-robin arbitration. The winning write is registered onto the write port. A 31-entry pending-write scoreboard tells the issue stage whether source or destination registers still have outstanding writes. The block sits between the execution units and the register file write interface (`rd_idx`, `wr_data`, `wr_en`).

## Interface
- XLEN, 64, data width of the register file.
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- alu_valid_i / lsu_valid_i / mdu_valid_i  input  1 each  writeback request from the ALU, LSU and MDU.
- alu_rd_i / lsu_rd_i / mdu_rd_i  input  5 each  destination register index.
- alu_data_i / lsu_data_i / mdu_data_i  input  XLEN each  writeback data.
- alu_ready_o / lsu_ready_o / mdu_ready_o  output  1 each  grant, combinational from the valids and the RR pointer.
- wr_en_o  output  1  register file write enable, registered.
- rd_idx_o  output  5  register file write index, registered.
- wr_data_o  output  XLEN  register file write data, registered.
- alloc_en_i  input  1  the issue stage dispatches an instruction that will write `alloc_rd_i`.
- alloc_rd_i  input  5  destination index being allocated.
- rs1_idx_i, rs2_idx_i  input  5 each  source indices being checked by issue.
- rs1_busy_o, rs2_busy_o, rd_busy_o  output  1 each  pending-write status for rs1, rs2 and alloc_rd; combinational.
- err_o  output  1  sticky flag for a WAW allocation violation.

## Operation
- **Arbitration**
  - At most one ready is asserted per cycle, and only to a requester whose valid is high.
  - Round-robin priority starts at the port after `last_grant`. Order: ALU(0) → LSU(1) → MDU(2) → ALU.
  - `last_grant` updates only on an accepted transfer (valid && ready). Reset value is 2, so the ALU has first priority after reset.
  - Handshake: a requester holds valid, rd and data stable until it sees ready. Dropping valid without a grant is illegal.
- **Write port**
  - An accepted transfer in cycle N drives `wr_en_o=1` with the granted rd and data in cycle N+1, for exactly one cycle.
  - A transfer with rd=0 is accepted and advances the pointer, but `wr_en_o` stays 0.
  - With no transfer, `wr_en_o=0` and `rd_idx_o`/`wr_data_o` hold their previous values.
- **Scoreboard** (pending[31:1]; x0 is never pending)
  - Set: `alloc_en_i` with `alloc_rd_i!=0` sets pending[alloc_rd_i] at the next edge.
  - Clear: `wr_en_o=1` clears pending[rd_idx_o] at the next edge.
  - Set and clear of the same index in the same cycle: set wins.
  - Clearing a non-pending register has no effect.
- **Busy outputs**
  - `rsX_busy_o = pending[rsX_idx_i] && !(wr_en_o && rd_idx_o==rsX_idx_i)`. The retiring write is forwarded by the register file's bypass, so it does not count as busy.
  - Index 0 always reads not-busy.
  - `rd_busy_o` is computed the same way on `alloc_rd_i`.
- **Errors**
  - `alloc_en_i` while `rd_busy_o=1` sets `err_o`. `err_o` stays 1 until reset.
  - The pending bit stays set in that case; there is no counting.

## Timing
- Reset values: `wr_en_o=0`, `rd_idx_o=0`, `wr_data_o=0`, pending=0, `err_o=0`, `last_grant=2`.
- While `rst_i` is high, all ready and busy outputs are 0.
- Reset asserted mid-operation discards any granted-but-unwritten transfer and clears the scoreboard immediately. The requester must re-present its request after reset.
- Grant latency: combinational, same cycle. The register file write lands at the edge ending cycle N+1.
- Throughput: one writeback per cycle, back-to-back with no bubbles.
- With all three requesters continuously valid, grants are ALU, LSU, MDU, ALU, …, so each source waits at most 2 cycles.
- Scoreboard latency:
  - An allocation in cycle N shows busy from cycle N+1.
  - A write on the port in cycle M shows not-busy in cycle M itself (forwarding) and clears at the edge ending M.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle → all outputs take their reset values immediately; after release with only the ALU valid (rd=5, data=0xA5) → `alu_ready_o=1` that cycle, and the next cycle shows `wr_en_o=1`, `rd_idx_o=5`, `wr_data_o=0xA5`.
- **Fairness:** all three valid for 6 cycles with rd=1,2,3 → grant order ALU, LSU, MDU, ALU, LSU, MDU; `wr_en_o` high for 6 consecutive cycles, one cycle after each grant.
- **x0 write:** LSU writes rd=0 → `lsu_ready_o=1`, `wr_en_o` stays 0, and the next grant goes to MDU when ALU and MDU are both valid.
- **Scoreboard life cycle:**
  - Allocate rd=7 → `rs1_busy_o=1` next cycle with `rs1_idx_i=7`.
  - MDU writeback of rd=7 → busy drops in the cycle `wr_en_o=1`.
  - Pending[7] is 0 afterwards.
- **Set/clear collision:** allocate rd=9 in the same cycle that `wr_en_o` retires rd=9 → pending[9] stays 1 and `rs2_busy_o=1` the following cycle.
- **WAW violation:** allocate rd=4, then allocate rd=4 again before its writeback → `err_o=1`, which stays 1 through later traffic until `rst_i`.
